unipolar_rz_receiver: RTL

Decodes a unipolar return-to-zero serial line (WS2812/SK6805-style LED protocol) back into parallel words. It measures each high pulse in clock cycles, classifies it as a 0 or a 1, and assembles DATA_WIDTH bits LSB-first. It detects the long-low reset/latch gap and reports malformed pulses. It sits at the far end of a `unipolar_rz` link and is used for loopback tests and for LED-chain sniffing.

---
 rtl/unipolar_rz_pkg.sv | 23 ++
 rtl/unipolar_rz_sync.sv | 30 +++
 rtl/unipolar_rz_receiver.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/unipolar_rz_pkg.sv
// Shared types and helpers for the unipolar return-to-zero receiver.
// Holds the FSM state encoding and the seconds-to-cycles conversion used
// to derive every timing limit from the clock rate.
package unipolar_rz_pkg;

    // Receiver FSM states:
    //   SYNC - waiting for a clean reset gap before trusting the line
    //   LOW  - between pulses, measuring low time
    //   HIGH - inside a pulse, measuring high time
    typedef enum logic [1:0] {
        SYNC = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } rz_rx_state_t;

    // Convert a duration in seconds to a whole number of clock cycles,
    // rounding to nearest. Durations are always positive, so adding one
    // half before truncation is enough.
    function automatic int time_to_cycles(real t, real rate);
        return $rtoi(t * rate + 0.5);
    endfunction

endpackage

// File: rtl/unipolar_rz_sync.sv
// Two-flop synchronizer for the asynchronous serial line, followed by one
// extra register so the caller can detect edges on the synchronized signal.
//   line_s   : line after two flops (safe to use in the clock domain)
//   line_s_d : line_s delayed by one more cycle
// Rising edge  = line_s & ~line_s_d
// Falling edge = ~line_s & line_s_d
module unipolar_rz_sync (
    input  logic clock,
    input  logic reset,
    input  logic line,
    output logic line_s,
    output logic line_s_d
);

    logic line_meta;

    // Synchronizer chain plus edge-detect delay; reset forces the line low.
    always_ff @(posedge clock) begin
        if (reset) begin
            line_meta <= 1'b0;
            line_s    <= 1'b0;
            line_s_d  <= 1'b0;
        end else begin
            line_meta <= line;
            line_s    <= line_meta;
            line_s_d  <= line_s;
        end
    end

endmodule

// File: rtl/unipolar_rz_receiver.sv
// Unipolar return-to-zero (WS2812/SK6805-style) receiver.
//
// Measures each high pulse on the synchronized line in clock cycles,
// classifies it as a 0 or 1 bit, and assembles DATA_WIDTH bits LSB first.
// A long low period is reported as a reset/latch gap. Pulses that are too
// short or too long, and words cut short by a gap, are reported as errors
// and force a resynchronization.
//
// Output protocol: valid, latch and error are single-cycle strobes with no
// ready/backpressure. data changes only in the cycle valid is high and then
// holds until the next complete word; a consumer must capture data in the
// valid cycle. valid never coincides with latch or error.
//
// The FSM state is exported on `state` so checkers can follow the decoder.
module unipolar_rz_receiver
    import unipolar_rz_pkg::*;
#(
    parameter int  DATA_WIDTH     = 24,
    parameter real CLOCK_RATE     = 100e6,
    parameter real ZERO_HIGH_TIME = 0.3e-6,
    parameter real ONE_HIGH_TIME  = 0.6e-6,
    parameter real RESET_TIME     = 80e-6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  line,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  latch,
    output logic                  error,
    output rz_rx_state_t          state
);

    // ------------------------------------------------------------------
    // Timing limits in clock cycles
    // ------------------------------------------------------------------
    localparam int Z = time_to_cycles(ZERO_HIGH_TIME, CLOCK_RATE);
    localparam int O = time_to_cycles(ONE_HIGH_TIME, CLOCK_RATE);
    localparam int R = time_to_cycles(RESET_TIME, CLOCK_RATE);

    // Shortest legal pulse, 0/1 decision point, longest legal pulse.
    localparam int HMIN   = Z / 2;
    localparam int THRESH = (Z + O) / 2;
    localparam int HMAX   = O + (O - Z) / 2;

    // Counter widths: the high counter must be able to hold HMAX+1 and the
    // low counter must be able to hold R.
    localparam int HW = $clog2(HMAX + 2);
    localparam int LW = $clog2(R + 1);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [HW-1:0] HMIN_C   = HW'(HMIN);
    localparam logic [HW-1:0] THRESH_C = HW'(THRESH);
    localparam logic [HW-1:0] HMAX_C   = HW'(HMAX);
    localparam logic [HW-1:0] HIGH_ONE = HW'(1);
    localparam logic [LW-1:0] R_C      = LW'(R);
    localparam logic [LW-1:0] R_LAST   = LW'(R - 1);
    localparam logic [LW-1:0] LOW_ONE  = LW'(1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    // ------------------------------------------------------------------
    // Line synchronization and edge detection
    // ------------------------------------------------------------------
    logic line_s;
    logic line_s_d;
    logic rise;
    logic fall;

    unipolar_rz_sync u_sync (
        .clock    (clock),
        .reset    (reset),
        .line     (line),
        .line_s   (line_s),
        .line_s_d (line_s_d)
    );

    assign rise = line_s & ~line_s_d;
    assign fall = ~line_s & line_s_d;

    // ------------------------------------------------------------------
    // Datapath state
    // ------------------------------------------------------------------
    logic [HW-1:0]         high_cnt;
    logic [LW-1:0]         low_cnt;
    logic [BW-1:0]         bit_count;
    logic [DATA_WIDTH-1:0] shift_reg;

    logic                  pulse_short;
    logic                  pulse_one;
    logic [DATA_WIDTH-1:0] word_next;

    // Classify the pulse just ended and form the word with that bit placed.
    always_comb begin
        pulse_short          = (high_cnt < HMIN_C);
        pulse_one            = (high_cnt >= THRESH_C);
        word_next            = shift_reg;
        word_next[bit_count] = pulse_one;
    end

    // ------------------------------------------------------------------
    // Decoder FSM with registered strobes
    // ------------------------------------------------------------------
    // Single sequential block: state, counters, shift register and outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= SYNC;
            high_cnt  <= '0;
            low_cnt   <= '0;
            bit_count <= '0;
            shift_reg <= '0;
            data      <= '0;
            valid     <= 1'b0;
            latch     <= 1'b0;
            error     <= 1'b0;
        end else begin
            valid <= 1'b0;
            latch <= 1'b0;
            error <= 1'b0;

            case (state)
                // Ignore all pulses until the line has been low for a full
                // reset gap. The gap that ends SYNC is not reported as a
                // latch, so the low counter is parked at its saturated value.
                SYNC: begin
                    if (line_s) begin
                        low_cnt <= '0;
                    end else if (low_cnt >= R_LAST) begin
                        state   <= LOW;
                        low_cnt <= R_C;
                    end else begin
                        low_cnt <= low_cnt + LOW_ONE;
                    end
                end

                // Between pulses: a rising edge starts a measurement, a
                // long enough low period is a latch gap (reported once).
                LOW: begin
                    if (rise) begin
                        state    <= HIGH;
                        high_cnt <= HIGH_ONE;
                    end else if (!line_s && (low_cnt < R_C)) begin
                        low_cnt <= low_cnt + LOW_ONE;
                        if (low_cnt == R_LAST) begin
                            latch <= 1'b1;
                            // A gap in the middle of a word drops the word.
                            if (bit_count != '0) begin
                                error     <= 1'b1;
                                bit_count <= '0;
                                shift_reg <= '0;
                                low_cnt   <= '0;
                                state     <= SYNC;
                            end
                        end
                    end
                end

                // Inside a pulse: on the falling edge classify the width;
                // give up as soon as the pulse outgrows the longest 1 bit.
                HIGH: begin
                    if (fall) begin
                        if (pulse_short) begin
                            error     <= 1'b1;
                            bit_count <= '0;
                            shift_reg <= '0;
                            low_cnt   <= '0;
                            state     <= SYNC;
                        end else begin
                            state   <= LOW;
                            low_cnt <= LOW_ONE;
                            if (bit_count == LAST_BIT) begin
                                data      <= word_next;
                                valid     <= 1'b1;
                                bit_count <= '0;
                                shift_reg <= '0;
                            end else begin
                                shift_reg <= word_next;
                                bit_count <= bit_count + BIT_ONE;
                            end
                        end
                    end else if (high_cnt >= HMAX_C) begin
                        error     <= 1'b1;
                        bit_count <= '0;
                        shift_reg <= '0;
                        low_cnt   <= '0;
                        state     <= SYNC;
                    end else begin
                        high_cnt <= high_cnt + HIGH_ONE;
                    end
                end

                default: begin
                    state     <= SYNC;
                    low_cnt   <= '0;
                    bit_count <= '0;
                    shift_reg <= '0;
                end
            endcase
        end
    end

endmodule
